// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes, condition
// codes, datapath select values and the data-processing command decoder.
package ctrl_pkg;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic [1:0] alu_ctl;
    logic       no_write;
  } cmd_dec_t;

  // CMP/TST compute like SUB/AND but only affect flags.
  function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
    cmd_dec_t d;
    d.no_write = 1'b0;
    case (cmd)
      4'b0100: d.alu_ctl = ALU_ADD;
      4'b0010: d.alu_ctl = ALU_SUB;
      4'b0000: d.alu_ctl = ALU_AND;
      4'b1100: d.alu_ctl = ALU_ORR;
      4'b1010: begin d.alu_ctl = ALU_SUB; d.no_write = 1'b1; end
      4'b1000: begin d.alu_ctl = ALU_AND; d.no_write = 1'b1; end
      default: d.alu_ctl = ALU_ADD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/condlogic.sv
// NZCV flag register and per-instruction condition-pass latch; the condition is
// evaluated once in DECODE against the flags as they stood before the instruction.
module condlogic
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       sample_cond,
  input  logic       exec,
  input  logic       s_bit,
  input  logic       no_write,
  input  logic [1:0] alu_ctl,
  output logic [3:0] flags,
  output logic       cond_ok
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ok_q, cond_ok_d;
  logic       nz_we, cv_we;

  function automatic logic condcheck(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      COND_EQ: condcheck = z;
      COND_NE: condcheck = ~z;
      COND_CS: condcheck = cf;
      COND_CC: condcheck = ~cf;
      COND_MI: condcheck = n;
      COND_PL: condcheck = ~n;
      COND_VS: condcheck = v;
      COND_VC: condcheck = ~v;
      COND_HI: condcheck = cf & ~z;
      COND_LS: condcheck = ~cf | z;
      COND_GE: condcheck = (n == v);
      COND_LT: condcheck = (n != v);
      COND_GT: condcheck = ~z & (n == v);
      COND_LE: condcheck = z | (n != v);
      COND_AL: condcheck = 1'b1;
      default: condcheck = 1'b0;
    endcase
  endfunction

  assign nz_we = exec & cond_ok_q & (s_bit | no_write);
  assign cv_we = nz_we & ((alu_ctl == ALU_ADD) | (alu_ctl == ALU_SUB));

  always_comb begin
    flags_d   = flags_q;
    cond_ok_d = cond_ok_q;
    if (nz_we) flags_d[3:2] = alu_flags[3:2];
    if (cv_we) flags_d[1:0] = alu_flags[1:0];
    if (sample_cond) cond_ok_d = condcheck(cond, flags_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ok_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
    end
  end

  assign flags   = flags_q;
  assign cond_ok = cond_ok_q;

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multi-cycle datapath: one micro-step per clock, with
// strobes gated by the instruction's condition and suppressed while in reset.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [19:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ImmSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUControl,
  output logic [3:0]         Flags,
  output logic [STATE_W-1:0] State
);

  logic [3:0] cond, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_rn;
  cmd_dec_t   cmd_dec;
  logic       cond_ok;

  logic [STATE_W-1:0] state_q, state_d, dec_state;
  logic pc_w, mem_w, ir_w, reg_w;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];
  assign cmd_dec   = decode_cmd(funct[4:1]);

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: case (op)
                OP_DP:   state_d = funct[5] ? EXECI : EXECR;
                OP_MEM:  state_d = MEMADR;
                OP_BR:   state_d = BRANCH;
                default: state_d = FETCH;
              endcase
      MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR, EXECI: state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Selects show the FETCH decode during reset so the datapath sees a clean state.
  assign dec_state = reset ? FETCH : state_q;

  always_comb begin
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_WD;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (dec_state)
      FETCH: begin
        ir_w = 1'b1; pc_w = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
      end
      MEMRD: AdrSrc = 1'b1;
      MEMWR: begin AdrSrc = 1'b1; mem_w = cond_ok; end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w = cond_ok;
        pc_w  = cond_ok & (rd == 4'd15);
      end
      EXECR: ALUControl = cmd_dec.alu_ctl;
      EXECI: begin ALUSrcB = SRCB_IMM; ALUControl = cmd_dec.alu_ctl; end
      ALUWB: begin
        reg_w = cond_ok & ~cmd_dec.no_write;
        pc_w  = cond_ok & (rd == 4'd15) & ~cmd_dec.no_write;
      end
      BRANCH: begin
        ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURESULT; pc_w = cond_ok;
      end
      default: ;
    endcase
  end

  assign PCWrite  = pc_w  & ~reset;
  assign MemWrite = mem_w & ~reset;
  assign IRWrite  = ir_w  & ~reset;
  assign RegWrite = reg_w & ~reset;
  assign ImmSrc   = op;
  assign RegSrc   = {op == OP_MEM, op == OP_BR};
  assign State    = state_q;

  condlogic u_condlogic (
    .clk         (clk),
    .reset       (reset),
    .cond        (cond),
    .alu_flags   (ALUFlags),
    .sample_cond (state_q == DECODE),
    .exec        ((state_q == EXECR) | (state_q == EXECI)),
    .s_bit       (funct[0]),
    .no_write    (cmd_dec.no_write),
    .alu_ctl     (cmd_dec.alu_ctl),
    .flags       (Flags),
    .cond_ok     (cond_ok)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: steps instructions through the controller and checks state path,
// strobes, selects and flags against hand-derived values each cycle.
module tb_multicycle_controller;

  logic        clk, reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl;
  logic [3:0]  Flags, State;
  logic [3:0]  strb;
  int passed = 0;
  int total = 0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .Flags(Flags), .State(State)
  );

  // {PCWrite, MemWrite, IRWrite, RegWrite}
  assign strb = {PCWrite, MemWrite, IRWrite, RegWrite};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] o,
                                     input logic [5:0] f, input logic [3:0] r);
    return {c, o, f, 4'h0, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Instr = 20'h0; ALUFlags = 4'h0;
    tick(); tick();
    total++; if (State !== 4'd0) $display("FAIL reset_state got %0d want 0", State); else passed++;
    total++; if (Flags !== 4'b0000) $display("FAIL reset_flags got %b want 0000", Flags); else passed++;
    total++; if (strb !== 4'b0000) $display("FAIL reset_strobes got %b want 0000", strb); else passed++;
    reset = 1'b0; #1;
    total++; if (strb !== 4'b1010) $display("FAIL post_reset_fetch got %b want 1010", strb); else passed++;
    $display("reset: state=%0d flags=%b strobes=%b", State, Flags, strb);
  endtask

  task automatic test_adds();
    Instr = mk(4'hE, 2'b00, 6'b101001, 4'd1); ALUFlags = 4'b0110; #1;
    total++; if (State !== 4'd0) $display("FAIL adds_fetch got %0d want 0", State); else passed++;
    tick();
    total++; if (State !== 4'd1) $display("FAIL adds_decode got %0d want 1", State); else passed++;
    total++; if (strb !== 4'b0000) $display("FAIL adds_decode_strb got %b want 0000", strb); else passed++;
    tick();
    total++; if (State !== 4'd7) $display("FAIL adds_execi got %0d want 7", State); else passed++;
    total++; if ({ALUSrcA, ALUSrcB, ALUControl} !== 5'b0_01_00) $display("FAIL adds_execi_sel got %b want 00100", {ALUSrcA, ALUSrcB, ALUControl}); else passed++;
    tick();
    total++; if (State !== 4'd8) $display("FAIL adds_aluwb got %0d want 8", State); else passed++;
    total++; if (strb !== 4'b0001) $display("FAIL adds_aluwb_strb got %b want 0001", strb); else passed++;
    total++; if (Flags !== 4'b0110) $display("FAIL adds_flags got %b want 0110", Flags); else passed++;
    tick();
    total++; if (State !== 4'd0) $display("FAIL adds_end got %0d want 0", State); else passed++;
    $display("ADDS R1: flags=%b", Flags);
  endtask

  task automatic test_cmp_beq(input logic [3:0] af, input logic taken);
    Instr = mk(4'hE, 2'b00, 6'b010101, 4'd0); ALUFlags = af; #1;
    tick(); tick();
    total++; if (State !== 4'd6) $display("FAIL cmp_execr got %0d want 6", State); else passed++;
    total++; if (ALUControl !== 2'b01) $display("FAIL cmp_aluctl got %b want 01", ALUControl); else passed++;
    tick();
    total++; if (strb !== 4'b0000) $display("FAIL cmp_aluwb_strb got %b want 0000", strb); else passed++;
    total++; if (Flags !== af) $display("FAIL cmp_flags got %b want %b", Flags, af); else passed++;
    tick();
    Instr = mk(4'h0, 2'b10, 6'b000000, 4'd0); ALUFlags = 4'b1111; #1;
    total++; if ({RegSrc, ImmSrc} !== 4'b0110) $display("FAIL beq_selects got %b want 0110", {RegSrc, ImmSrc}); else passed++;
    tick(); tick();
    total++; if (State !== 4'd9) $display("FAIL beq_branch got %0d want 9", State); else passed++;
    total++; if (strb !== {taken, 3'b000}) $display("FAIL beq_pcwrite got %b want %b", strb, {taken, 3'b000}); else passed++;
    tick();
    total++; if (State !== 4'd0) $display("FAIL beq_end got %0d want 0", State); else passed++;
    $display("CMP/BEQ: flags=%b branch_taken=%b", Flags, taken);
  endtask

  task automatic test_ldr_pc();
    Instr = mk(4'hE, 2'b01, 6'b011001, 4'd15); ALUFlags = 4'b0000; #1;
    total++; if (RegSrc !== 2'b10) $display("FAIL ldr_regsrc got %b want 10", RegSrc); else passed++;
    tick(); tick();
    total++; if ({State, ALUSrcB, ALUControl} !== {4'd2, 2'b01, 2'b00}) $display("FAIL ldr_memadr got %b want 0010_01_00", {State, ALUSrcB, ALUControl}); else passed++;
    tick();
    total++; if ({State, AdrSrc} !== {4'd3, 1'b1}) $display("FAIL ldr_memrd got %b want 00111", {State, AdrSrc}); else passed++;
    tick();
    total++; if (State !== 4'd4) $display("FAIL ldr_memwb got %0d want 4", State); else passed++;
    total++; if ({ResultSrc, strb} !== {2'b01, 4'b1001}) $display("FAIL ldr_memwb_out got %b want 011001", {ResultSrc, strb}); else passed++;
    tick();
    total++; if (State !== 4'd0) $display("FAIL ldr_end got %0d want 0", State); else passed++;
    $display("LDR R15: 5-cycle path complete");
  endtask

  task automatic test_str(input logic [3:0] c, input logic exp_mw);
    Instr = mk(c, 2'b01, 6'b010000, 4'd2); #1;
    tick(); tick();
    total++; if ({State, ALUControl} !== {4'd2, 2'b01}) $display("FAIL str_memadr got %b want 001001", {State, ALUControl}); else passed++;
    tick();
    total++; if ({State, AdrSrc} !== {4'd5, 1'b1}) $display("FAIL str_memwr got %b want 01011", {State, AdrSrc}); else passed++;
    total++; if (strb !== {1'b0, exp_mw, 2'b00}) $display("FAIL str_memwrite got %b want %b", strb, {1'b0, exp_mw, 2'b00}); else passed++;
    tick();
    total++; if (State !== 4'd0) $display("FAIL str_end got %0d want 0", State); else passed++;
    $display("STR cond=%h: memwrite=%b", c, exp_mw);
  endtask

  task automatic test_undef();
    Instr = mk(4'hE, 2'b11, 6'b000000, 4'd15); #1;
    tick();
    total++; if ({State, strb} !== {4'd1, 4'b0000}) $display("FAIL undef_decode got %b want 00010000", {State, strb}); else passed++;
    tick();
    total++; if (State !== 4'd0) $display("FAIL undef_back got %0d want 0", State); else passed++;
    $display("undefined op: returned to FETCH");
  endtask

  task automatic test_reset_mid();
    total++; if (Flags !== 4'b0100) $display("FAIL pre_reset_flags got %b want 0100", Flags); else passed++;
    Instr = mk(4'hE, 2'b01, 6'b011001, 4'd3); #1;
    tick(); tick(); tick();
    total++; if (State !== 4'd3) $display("FAIL mid_memrd got %0d want 3", State); else passed++;
    reset = 1'b1; #1;
    total++; if (strb !== 4'b0000) $display("FAIL mid_reset_strb got %b want 0000", strb); else passed++;
    tick();
    total++; if ({State, Flags, strb} !== 12'h000) $display("FAIL mid_reset_after got %b want 0", {State, Flags, strb}); else passed++;
    reset = 1'b0; #1;
    total++; if (strb !== 4'b1010) $display("FAIL mid_release got %b want 1010", strb); else passed++;
    $display("reset in MEMRD: state=%0d flags=%b", State, Flags);
  endtask

  initial begin
    test_reset();
    test_adds();
    test_cmp_beq(4'b0100, 1'b1);
    test_cmp_beq(4'b0010, 1'b0);
    test_ldr_pc();
    test_cmp_beq(4'b0100, 1'b1);
    test_str(4'h1, 1'b0);
    test_str(4'hE, 1'b1);
    test_undef();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
